inst_loader: RTL and testbench

INST_LOADER -- requirements
Module: inst_loader

---
 rtl/inst_loader_pkg.sv | 18 +
 rtl/inst_loader_word_packer.sv | 32 +++
 rtl/inst_loader.sv | 141 ++++++++++++++
 tb/tb_inst_loader.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/inst_loader_pkg.sv
// Shared definitions for the instruction loader: widths and FSM encodings.
// Optional checksum stage is enabled by defining INST_LOADER_CHECKSUM_EN.
package inst_loader_pkg;

    localparam int WORD_W = 32;
    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_COUNT = 3'd1,
        S_DATA  = 3'd2,
        S_WRITE = 3'd3,
        S_CHECK = 3'd4,
        S_DONE  = 3'd5,
        S_ERROR = 3'd6
    } state_t;

endpackage

// File: rtl/inst_loader_word_packer.sv
// Byte-to-word packer, most-significant byte first.
// Pulses o_word_valid in the cycle the fourth byte is accepted.
module word_packer
    import inst_loader_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clear,
    input  logic              i_valid,
    input  logic [BYTE_W-1:0] i_byte,
    output logic [WORD_W-1:0] o_word,
    output logic              o_word_valid
);

    logic [WORD_W-BYTE_W-1:0] r_shift;
    logic [1:0]               r_cnt;

    // Shift in accepted bytes; stalls simply hold the partial word.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clear) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (i_valid) begin
            r_shift <= {r_shift[WORD_W-2*BYTE_W-1:0], i_byte};
            r_cnt   <= r_cnt + 2'd1;
        end
    end

    assign o_word       = {r_shift, i_byte};
    assign o_word_valid = i_valid && (r_cnt == 2'd3);

endmodule

// File: rtl/inst_loader.sv
// Serial program loader: count word, N data words, optional checksum.
// Define INST_LOADER_CHECKSUM_EN to add the XOR checksum CHECK stage.
module inst_loader
    import inst_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 256
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [7:0]  byte_data,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        inst_mem_load_enable,
    output logic [31:0] inst_mem_write_addr,
    output logic [31:0] inst_mem_write_data,
    output logic        pc_hold,
    output logic        done,
    output logic        error
);

`ifdef INST_LOADER_CHECKSUM_EN
    localparam state_t S_FINISH = S_CHECK;
`else
    localparam state_t S_FINISH = S_DONE;
`endif

    state_t              r_state;
    logic                r_have_n;
    logic [WORD_W-1:0]   r_words;
    logic [WORD_W-1:0]   r_wcnt;
    logic [WORD_W-1:0]   r_addr;
    logic [WORD_W-1:0]   r_data;
    logic                r_load_en;
`ifdef INST_LOADER_CHECKSUM_EN
    logic [WORD_W-1:0]   r_csum;
`endif

    logic                w_accept;
    logic                w_rearm;
    logic [WORD_W-1:0]   w_word;
    logic                w_word_valid;

    // The count word waits one cycle in COUNT (r_have_n) for the range decision.
    assign byte_ready = ((r_state == S_COUNT) && !r_have_n)
                     || (r_state == S_DATA)
                     || (r_state == S_CHECK);
    assign w_accept   = byte_valid && byte_ready;
    assign w_rearm    = start && ((r_state == S_IDLE)
                                || (r_state == S_DONE)
                                || (r_state == S_ERROR));

    word_packer u_packer (
        .i_clk        (clock),
        .i_rst_n      (reset_n),
        .i_clear      (w_rearm),
        .i_valid      (w_accept),
        .i_byte       (byte_data),
        .o_word       (w_word),
        .o_word_valid (w_word_valid)
    );

    // Load session FSM with registered strobe, address and data.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_have_n  <= 1'b0;
            r_words   <= '0;
            r_wcnt    <= '0;
            r_addr    <= BASE_ADDR;
            r_data    <= '0;
            r_load_en <= 1'b0;
`ifdef INST_LOADER_CHECKSUM_EN
            r_csum    <= '0;
`endif
        end else begin
            r_load_en <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        r_state  <= S_COUNT;
                        r_have_n <= 1'b0;
                        r_wcnt   <= '0;
                        r_addr   <= BASE_ADDR;
`ifdef INST_LOADER_CHECKSUM_EN
                        r_csum   <= '0;
`endif
                    end
                end
                S_COUNT: begin
                    if (r_have_n) begin
                        r_have_n <= 1'b0;
                        if (r_words == '0)
                            r_state <= S_FINISH;
                        else if (r_words > MAX_WORDS)
                            r_state <= S_ERROR;
                        else
                            r_state <= S_DATA;
                    end else if (w_word_valid) begin
                        r_words  <= w_word;
                        r_have_n <= 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_word_valid) begin
                        r_state   <= S_WRITE;
                        r_data    <= w_word;
                        r_load_en <= 1'b1;
                    end
                end
                S_WRITE: begin
                    r_addr <= r_addr + 32'd4;
                    r_wcnt <= r_wcnt + 32'd1;
`ifdef INST_LOADER_CHECKSUM_EN
                    r_csum <= r_csum ^ r_data;
`endif
                    if (r_wcnt + 32'd1 == r_words)
                        r_state <= S_FINISH;
                    else
                        r_state <= S_DATA;
                end
`ifdef INST_LOADER_CHECKSUM_EN
                S_CHECK: begin
                    if (w_word_valid)
                        r_state <= (w_word == r_csum) ? S_DONE : S_ERROR;
                end
`endif
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign inst_mem_load_enable = r_load_en;
    assign inst_mem_write_addr  = r_addr;
    assign inst_mem_write_data  = r_data;
    assign pc_hold              = (r_state != S_DONE);
    assign done                 = (r_state == S_DONE);
    assign error                = (r_state == S_ERROR);

endmodule

// File: tb/tb_inst_loader.sv
// Scoreboard bench for inst_loader with a session-level reference model.
// Checksum sessions are exercised when INST_LOADER_CHECKSUM_EN is defined.
module tb_inst_loader;

    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int unsigned MAXW = 256;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic [7:0]  byte_data;
    logic        byte_valid;
    logic        byte_ready;
    logic        le;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic        pc_hold;
    logic        done;
    logic        error;

    int n_pass = 0;
    int n_total = 0;

    wr_t         exp_q[$];
    logic [31:0] words[$];

    inst_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
        .clock                (clock),
        .reset_n              (reset_n),
        .start                (start),
        .byte_data            (byte_data),
        .byte_valid           (byte_valid),
        .byte_ready           (byte_ready),
        .inst_mem_load_enable (le),
        .inst_mem_write_addr  (waddr),
        .inst_mem_write_data  (wdata),
        .pc_hold              (pc_hold),
        .done                 (done),
        .error                (error)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    // Monitor: pops expected writes and checks strobe latency.
    int  acc_cnt = 0;
    bit  prev_acc = 0;
    always @(negedge clock) begin
        if (!reset_n) begin
            acc_cnt  = 0;
            prev_acc = 0;
        end else begin
            if (le) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_strobe", waddr, 32'hxxxx_xxxx);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    chk("wr_addr", waddr, e.a);
                    chk("wr_data", wdata, e.d);
                    chk("wr_latency",
                        {31'd0, prev_acc && (acc_cnt % 4 == 0) && (acc_cnt >= 8)},
                        32'd1);
                end
            end
            if (start) acc_cnt = 0;
            prev_acc = byte_valid && byte_ready;
            if (prev_acc) acc_cnt++;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int mode);
        bit acc;
        int guard;
        if (mode == 1) begin
            byte_valid = 1'b0;
            tick();
        end else if (mode == 2) begin
            byte_valid = 1'b0;
            repeat ($urandom % 3) tick();
        end
        byte_data  = b;
        byte_valid = 1'b1;
        acc = 0;
        guard = 0;
        while (!acc && guard < 50) begin
            @(negedge clock);
            acc = byte_ready;
            tick();
            guard++;
        end
        byte_valid = 1'b0;
        if (!acc) chk("byte_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_word(input logic [31:0] w, input int mode);
        for (int k = 3; k >= 0; k--) send_byte(w[k*8 +: 8], mode);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic chk_reset();
        chk("rst_pc_hold", {31'd0, pc_hold}, 32'd1);
        chk("rst_le", {31'd0, le}, 32'd0);
        chk("rst_addr", waddr, BASE);
        chk("rst_data", wdata, 32'd0);
        chk("rst_ready", {31'd0, byte_ready}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_error", {31'd0, error}, 32'd0);
    endtask

    // Reference: N in range writes words[i] to BASE+4i; checksum is XOR of all.
    task automatic run_session(input logic [31:0] n, input int mode,
                               input bit bad);
        bit ok;
        int guard;
        logic [31:0] csum;
        ok = (n <= MAXW);
        csum = 32'd0;
        if (ok) begin
            for (int i = 0; i < int'(n); i++) begin
                exp_q.push_back('{a: BASE + 32'(4 * i), d: words[i]});
                csum = csum ^ words[i];
            end
        end
        pulse_start();
        send_word(n, mode);
        if (ok) begin
            for (int i = 0; i < int'(n); i++) send_word(words[i], mode);
`ifdef INST_LOADER_CHECKSUM_EN
            send_word(bad ? (csum ^ 32'h1) : csum, mode);
            ok = !bad;
`endif
        end
        guard = 0;
        while (!(done || error) && guard < 20) begin
            tick();
            guard++;
        end
        chk("end_timeout", {31'd0, guard < 20}, 32'd1);
        chk("done", {31'd0, done}, {31'd0, ok});
        chk("error", {31'd0, error}, {31'd0, !ok});
        chk("pc_hold", {31'd0, pc_hold}, {31'd0, !ok});
        chk("drain", exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        reset_n    = 1'b0;
        start      = 1'b0;
        byte_data  = 8'h00;
        byte_valid = 1'b0;
        repeat (2) tick();
        chk_reset();
        reset_n = 1'b1;
        tick();

        words = '{32'h2008_0005, 32'h8C09_0004};
        run_session(32'd2, 0, 1'b0);
        run_session(32'd2, 1, 1'b0);
`ifdef INST_LOADER_CHECKSUM_EN
        run_session(32'd2, 0, 1'b1);
`endif

        run_session(32'd257, 0, 1'b0);

`ifndef INST_LOADER_CHECKSUM_EN
        pulse_start();
        send_word(32'd0, 0);
        chk("zero_early", {31'd0, done}, 32'd0);
        tick();
        chk("zero_done", {31'd0, done}, 32'd1);
`endif

        words = '{32'h1111_2222, 32'h3333_4444, 32'h5555_6666};
        exp_q.push_back('{a: BASE, d: words[0]});
        pulse_start();
        send_word(32'd3, 0);
        send_word(words[0], 0);
        send_byte(8'h33, 0);
        send_byte(8'h33, 0);
        reset_n = 1'b0;
        tick();
        chk_reset();
        chk("mid_drain", exp_q.size(), 32'd0);
        exp_q.delete();
        reset_n = 1'b1;
        tick();
        words = '{32'hCAFE_0001, 32'hBEEF_0002};
        run_session(32'd2, 0, 1'b0);

        for (int s = 0; s < 12; s++) begin
            logic [31:0] n;
            if ($urandom % 8 == 0) n = 32'd257 + ($urandom % 1000);
            else n = 32'($urandom_range(1, 6));
            words.delete();
            for (int i = 0; i < 6; i++) words.push_back($urandom);
            run_session(n, int'($urandom % 3), ($urandom % 4) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
